// File: rtl/ds_adc_pkg.sv
// Shared pin map, constants and helpers for the multi-channel delta-sigma ADC tile.
package ds_adc_pkg;

    // ui_in
    localparam int unsigned COMP_LSB = 0;
    localparam int unsigned SEL      = 4;
    localparam int unsigned SCAN     = 6;
    localparam int unsigned FREEZE   = 7;
    // uio_in
    localparam int unsigned OVF_CLR  = 7;
    // uio_out
    localparam int unsigned VALID    = 4;
    localparam int unsigned FRAME    = 5;
    localparam int unsigned OVF      = 6;

    localparam logic [7:0] UIO_OE = 8'h7F;

    localparam int unsigned CHANNELS_MAX = 4;
    localparam int unsigned OSR_LOG2_MIN = 4;
    localparam int unsigned OSR_LOG2_MAX = 8;

    function automatic bit params_ok(int unsigned channels, int unsigned osr_log2);
        return (channels >= 1) && (channels <= CHANNELS_MAX) &&
               (osr_log2 >= OSR_LOG2_MIN) && (osr_log2 <= OSR_LOG2_MAX);
    endfunction

    function automatic logic [1:0] next_rr(logic [1:0] rr, int unsigned channels);
        return (32'(rr) + 32'd1 >= channels) ? 2'd0 : rr + 2'd1;
    endfunction

endpackage

// File: rtl/ds_adc_channel.sv
// One delta-sigma channel: comparator synchroniser, 1-bit feedback, window accumulator,
// saturating sample and sticky overflow flag.
module ds_adc_channel
    import ds_adc_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                comp,
    input  logic                eow,
    input  logic                ovf_clr,
    output logic                fb,
    output logic [OSR_LOG2-1:0] sample,
    output logic                ovf
);

    logic                s1_q;
    logic                s2_q;
    logic [OSR_LOG2:0]   acc_q;
    logic [OSR_LOG2:0]   total;
    logic                full;
    logic                ovf_q;

    assign total = acc_q + {{OSR_LOG2{1'b0}}, s2_q};
    // At most 2^OSR_LOG2 ones fit in a window, so the MSB alone marks a full count.
    assign full   = total[OSR_LOG2];
    assign sample = full ? {OSR_LOG2{1'b1}} : total[OSR_LOG2-1:0];
    assign fb     = s2_q;
    assign ovf    = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (ena) begin
            s1_q  <= comp;
            s2_q  <= s1_q;
            acc_q <= eow ? '0 : total;
            if (eow && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tt_um_fountaincoder_ds_adc_mc.sv
// Multi-channel delta-sigma ADC back-end: per-channel accumulators, shared window counter,
// fixed or round-robin display of one 8-bit sample per window.
module tt_um_fountaincoder_ds_adc_mc
    import ds_adc_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned OSR_LOG2 = 6
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    if (!params_ok(CHANNELS, OSR_LOG2)) begin : g_bad_params
        $error("ds_adc: CHANNELS must be 1..4 and OSR_LOG2 4..8");
    end

    logic [OSR_LOG2-1:0] win_q;
    logic                eow;
    logic [3:0]          fb;
    logic [3:0]          ovf;
    logic [OSR_LOG2-1:0] sample      [4];
    logic [7:0]          sample_byte [4];
    logic [1:0]          rr_q;
    logic [1:0]          disp_q;
    logic [1:0]          disp_ch;
    logic [7:0]          uo_q;
    logic                valid_q;
    logic                frame_q;
    logic                unused_in;

    assign eow = (win_q == {OSR_LOG2{1'b1}});

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < CHANNELS) begin : g_on
            ds_adc_channel #(
                .OSR_LOG2 (OSR_LOG2)
            ) u_channel (
                .clk     (clk),
                .rst_n   (rst_n),
                .ena     (ena),
                .comp    (ui_in[COMP_LSB + c]),
                .eow     (eow),
                .ovf_clr (uio_in[OVF_CLR]),
                .fb      (fb[c]),
                .sample  (sample[c]),
                .ovf     (ovf[c])
            );
        end else begin : g_off
            assign fb[c]     = 1'b0;
            assign ovf[c]    = 1'b0;
            assign sample[c] = '0;
        end
        assign sample_byte[c] = 8'(sample[c]) << (8 - OSR_LOG2);
    end

    assign disp_ch = ui_in[SCAN] ? rr_q : ui_in[SEL +: 2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= '0;
            rr_q    <= 2'd0;
            disp_q  <= 2'd0;
            uo_q    <= 8'd0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else if (ena) begin
            win_q   <= win_q + 1'b1;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            // Freeze only gates the display side; accumulation runs on in the channels.
            if (eow && !ui_in[FREEZE]) begin
                uo_q    <= sample_byte[disp_ch];
                valid_q <= 1'b1;
                frame_q <= ui_in[SCAN] && (disp_ch == 2'd0);
                disp_q  <= disp_ch;
                if (ui_in[SCAN]) begin
                    rr_q <= next_rr(rr_q, CHANNELS);
                end
            end
        end
    end

    always_comb begin
        uio_out        = 8'd0;
        uio_out[3:0]   = fb;
        uio_out[VALID] = valid_q;
        uio_out[FRAME] = frame_q;
        uio_out[OVF]   = ovf[disp_q];
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE;

    assign unused_in = &{1'b0, uio_in[6:0], ui_in[3:0]};

endmodule

// File: doc/tt_um_fountaincoder_ds_adc_mc.md
# tt_um_fountaincoder_ds_adc_mc

Multi-channel first-order delta-sigma ADC back-end for a TinyTapeout tile; next generation of the single-channel AD top. An external RC integrator and comparator sit on each `ui_in` comparator pin. This block resynchronises each comparator bit, drives it back as 1-bit DAC feedback, and counts ones over a 2^OSR_LOG2-cycle window. It publishes one 8-bit sample per window on `uo_out`, in fixed-channel or round-robin scan mode.

## Interface
- `CHANNELS`, 4 — active channels, 1..4.
- `OSR_LOG2`, 6 — log2 of window length, 4..8.
- `clk` in 1 — clock; one clock domain.
- `rst_n` in 1 — synchronous, active-low reset.
- `ena` in 1 — tile enable; 0 freezes all state.
- `ui_in` in 8 — [3:0] comparator bits ch0..3 (asynchronous); [5:4] channel select; [6] scan mode; [7] freeze.
- `uio_in` in 8 — [7] overflow clear; others ignored.
- `uo_out` out 8 — displayed sample byte.
- `uio_out` out 8 — [3:0] feedback ch0..3; [4] valid; [5] frame start; [6] overflow of displayed channel; [7] 0.
- `uio_oe` out 8 — constant 8'h7F.

## Operation
- Reset values (`rst_n`=0 at an edge): every register 0, so `uo_out`=0 and `uio_out`=0. `uio_oe` is 8'h7F always, including in reset.
- `ena`=0: no register updates; outputs hold.
- Per channel c < CHANNELS:
  - Two-flop synchroniser s1, s2 on `ui_in[c]`.
  - Feedback `fb[c]` = s2.
  - `acc[c]` is OSR_LOG2+1 bits.
- Channels c ≥ CHANNELS: feedback, sample and flag tied to 0.
- Window counter `win` is OSR_LOG2 bits, free-running, wraps 2^OSR_LOG2−1 → 0.
- When `win` is not at its terminal value: `acc[c] += s2[c]`.
- On the terminal value (end of window, EOW):
  - total = acc+s2; `acc` is cleared to 0.
  - If total == 2^OSR_LOG2: sample = 2^OSR_LOG2−1 and `ovf[c]` is set (sticky).
  - Otherwise sample = total, OSR_LOG2 bits.
  - byte = sample << (8−OSR_LOG2).
- Display at EOW, unless freeze (`ui_in[7]`) is set:
  - Displayed channel d = `rr` if scan mode is on, else the `ui_in[5:4]` select.
  - `uo_out` register <= byte of d; a select ≥ CHANNELS gives 0.
  - Valid register <= 1.
  - In scan mode, `rr` <= (rr+1) mod CHANNELS.
- Freeze: accumulation continues; the display, valid and `rr` hold.
- `uio_out[5]` = valid AND scan mode AND d==0, registered with valid.
- `uio_out[6]` = `ovf` of the last displayed channel, live.
- `uio_in[7]`=1 clears all `ovf`. If a set and a clear occur in the same cycle, set wins.
- Changes to select or scan mode take effect at the next EOW.
- On leaving scan mode, `rr` is kept.

## Timing
- Comparator edge to feedback pin: 2 cycles.
- A window is exactly 2^OSR_LOG2 cycles of s2 bits, with no gap.
- EOW edge: `uo_out` updates and valid rises. Valid is high for exactly one cycle per window.
- Sample period: 2^OSR_LOG2 cycles.
- Reset mid-window: the partial window is discarded; the first valid comes 2^OSR_LOG2 cycles after reset release.
- `ena` low mid-window stretches the window; no bits are lost or double counted.

## Structure
- Package `ds_adc_pkg`:
  - Pin index constants: COMP_LSB, SEL, SCAN, FREEZE, OVF_CLR, VALID, FRAME, OVF.
  - `UIO_OE` = 8'h7F.
  - Parameter range checks.
- Sub-module `ds_adc_channel`:
  - Contains the synchroniser, feedback, accumulator, saturation and sticky `ovf`.
  - Inputs: `eow`, `ovf_clr`, `ena`.
  - Outputs: `fb`, sample, `ovf`.
- Top instantiates CHANNELS copies, plus the window counter, display mux and `rr`.

## Test plan
- OSR_LOG2=4, `ui_in[0]`=1 held → valid every 16 cycles; `uo_out`=0xF0; `uio_out[6]`=1.
- OSR_LOG2=4, ch0 toggling every cycle → `uo_out`=0x80, `ovf` stays 0. Then `uio_in[7]` pulse after an overflow → flag clears. Set and clear in the same cycle → flag stays 1.
- CHANNELS=4, scan mode, duty 0/25/50/100% → `uo_out` sequence 0x00, 0x40, 0x80, 0xF0 repeating; `uio_out[5]` high only with ch0.
- Freeze raised → `uo_out` holds and no valid. Freeze released → next EOW shows the current window's value.
- Select=3 with CHANNELS=2 → `uo_out`=0; `uio_out[3:2]`=0.
- Reset asserted mid-window → all outputs 0 and `uio_oe`=0x7F; first valid exactly 2^OSR_LOG2 cycles after release. `ena` low for 5 cycles → window stretched by 5 cycles, count unchanged.
